// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the two-master SDRAM arbiter.
//   state_e     : arbiter FSM states
//   master_id_t : identifies which master issued a command (0 = m0, 1 = m1)
//   Def*        : default widths and read-tracking depth
package sdram_arb_pkg;

  localparam int unsigned DefAddrW      = 22;  // 12 row + 8 col + 2 bank
  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefMaxPending = 4;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  typedef logic master_id_t;

endpackage

// File: rtl/sdram_arb_2m_if.sv
// Avalon-MM pipelined-read bus bundle.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdata/readdatavalid
//   slave modport  : the mirror image
interface sdram_arb_2m_if #(
  parameter int unsigned ADDR_W = sdram_arb_pkg::DefAddrW,
  parameter int unsigned DATA_W = sdram_arb_pkg::DefDataW
) ();

  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_arb_id_fifo.sv
// Tracks the issuing master of each outstanding read, in issue order.
//   clk, rst : clock, synchronous active-high reset
//   push/din : record the master ID of an accepted read
//   pop      : retire the head when read data returns
//   head     : master ID of the oldest outstanding read
//   full     : Depth reads outstanding
//   empty    : no reads outstanding
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned Depth = DefMaxPending  // power of two, >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  master_id_t din,
  output master_id_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned  PtrW      = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  master_id_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntOne;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntOne;
      end
    end
  end

endmodule

// File: rtl/sdram_arb_2m.sv
// Round-robin arbiter sharing one SDRAM controller port between two Avalon masters.
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   m0, m1               : master-facing ports (slave modport)
//   s                    : controller-facing port (master modport), registered command
//   err_unexpected_rdv   : sticky, read data arrived with nothing outstanding
module sdram_arb_2m
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned MAX_PENDING = DefMaxPending
) (
  input  logic           clk_clk,
  input  logic           reset_reset,
  sdram_arb_2m_if.slave  m0,
  sdram_arb_2m_if.slave  m1,
  sdram_arb_2m_if.master s,
  output logic           err_unexpected_rdv
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  master_id_t        grant_q, grant_d;
  master_id_t        last_grant_q, last_grant_d;
  master_id_t        pick;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_address_q, s_address_d;
  logic [DATA_W-1:0] s_writedata_q, s_writedata_d;
  logic [BE_W-1:0]   s_byteenable_q, s_byteenable_d;
  logic              err_q, err_d;

  logic       fifo_full, fifo_empty;
  master_id_t fifo_head;
  logic       take_rd0, take_rd1, elig0, elig1;
  logic       accept, push, pop;

  // A read is only taken while a tracking slot is free; if read and write are both
  // asserted the read wins, and the write goes out only when the read is blocked.
  assign take_rd0 = m0.read & ~fifo_full;
  assign take_rd1 = m1.read & ~fifo_full;
  assign elig0    = m0.write | take_rd0;
  assign elig1    = m1.write | take_rd1;

  assign accept = (state_q == StBusy) & ~s.waitrequest;
  assign push   = accept & s_read_q;
  assign pop    = s.readdatavalid & ~fifo_empty;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    s_read_d       = s_read_q;
    s_write_d      = s_write_q;
    s_address_d    = s_address_q;
    s_writedata_d  = s_writedata_q;
    s_byteenable_d = s_byteenable_q;
    pick           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          // On a tie the master that did not win last time gets the slot.
          pick         = (elig0 & elig1) ? ~last_grant_q : elig1;
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = StBusy;
          if (pick == 1'b0) begin
            s_address_d    = m0.address;
            s_writedata_d  = m0.writedata;
            s_byteenable_d = m0.byteenable;
            s_read_d       = take_rd0;
            s_write_d      = ~take_rd0;
          end else begin
            s_address_d    = m1.address;
            s_writedata_d  = m1.writedata;
            s_byteenable_d = m1.byteenable;
            s_read_d       = take_rd1;
            s_write_d      = ~take_rd1;
          end
        end
      end
      StBusy: begin
        if (!s.waitrequest) begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          state_d   = StIdle;
        end
      end
    endcase
    err_d = err_q | (s.readdatavalid & fifo_empty);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= StIdle;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      s_address_q    <= '0;
      s_writedata_q  <= '0;
      s_byteenable_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      s_read_q       <= s_read_d;
      s_write_q      <= s_write_d;
      s_address_q    <= s_address_d;
      s_writedata_q  <= s_writedata_d;
      s_byteenable_q <= s_byteenable_d;
      err_q          <= err_d;
    end
  end

  sdram_arb_id_fifo #(
    .Depth(MAX_PENDING)
  ) u_id_fifo (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .push (push),
    .pop  (pop),
    .din  (grant_q),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign s.address    = s_address_q;
  assign s.read       = s_read_q;
  assign s.write      = s_write_q;
  assign s.writedata  = s_writedata_q;
  assign s.byteenable = s_byteenable_q;

  assign m0.waitrequest = ~(accept & (grant_q == 1'b0));
  assign m1.waitrequest = ~(accept & (grant_q == 1'b1));

  // Read data is shared; only the valid strobe is steered by the oldest ID.
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = pop & (fifo_head == 1'b0);
  assign m1.readdatavalid = pop & (fifo_head == 1'b1);

  assign err_unexpected_rdv = err_q;

endmodule

// File: tb/tb_sdram_arb_2m.sv
// Directed bench for sdram_arb_2m with a transaction-level reference model.
module tb_sdram_arb_2m;
  import sdram_arb_pkg::*;

  localparam int unsigned AW   = 22;
  localparam int unsigned DW   = 16;
  localparam int unsigned BW   = 2;
  localparam int unsigned MAXP = 4;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic err;

  sdram_arb_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  sdram_arb_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  sdram_arb_2m_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  sdram_arb_2m #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .m0                (m0_if),
    .m1                (m1_if),
    .s                 (s_if),
    .err_unexpected_rdv(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk_rd(input logic [AW-1:0] a);
    req_t r;
    r.rd = 1'b1; r.wr = 1'b0; r.addr = a; r.data = '0; r.be = 2'b11;
    return r;
  endfunction

  function automatic req_t mk_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [BW-1:0] b);
    req_t r;
    r.rd = 1'b0; r.wr = 1'b1; r.addr = a; r.data = d; r.be = b;
    return r;
  endfunction

  function automatic logic [DW-1:0] qget(input logic [DW-1:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 16'hDEAD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Avalon master BFMs: present the head request, retire it when waitrequest drops.
  req_t q0[$];
  req_t q1[$];

  always begin
    @(posedge clk);
    #2;
    if (q0.size() > 0) begin
      m0_if.read = q0[0].rd; m0_if.write = q0[0].wr; m0_if.address = q0[0].addr;
      m0_if.writedata = q0[0].data; m0_if.byteenable = q0[0].be;
    end else begin
      m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
      m0_if.writedata = '0; m0_if.byteenable = '0;
    end
    if (q1.size() > 0) begin
      m1_if.read = q1[0].rd; m1_if.write = q1[0].wr; m1_if.address = q1[0].addr;
      m1_if.writedata = q1[0].data; m1_if.byteenable = q1[0].be;
    end else begin
      m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
      m1_if.writedata = '0; m1_if.byteenable = '0;
    end
    @(negedge clk);
    if (!m0_if.waitrequest && q0.size() > 0) void'(q0.pop_front());
    if (!m1_if.waitrequest && q1.size() > 0) void'(q1.pop_front());
  end

  // Reference model: the controller sees at most one command at a time; reads
  // are remembered by issuing master in a queue and data is handed out in order.
  bit         chk_en = 1'b0;
  req_t       m_cmd = '{rd: 1'b0, wr: 1'b0, addr: '0, data: '0, be: '0};
  master_id_t m_grant = 1'b0;
  master_id_t m_last = 1'b1;
  bit         m_err = 1'b0;
  master_id_t m_ids[$];

  logic [DW-1:0] rx0[$];
  logic [DW-1:0] rx1[$];
  master_id_t    acc_order[$];
  int            cnt_stall_wr = 0;
  int            cnt_wr0_low = 0;
  int            cnt_wr1_low = 0;

  always @(negedge clk) begin : compare_p
    bit         acc, e0, e1, t0, t1, x0, x1;
    master_id_t g;
    int         occ;
    if (chk_en) begin
      acc = (m_cmd.rd || m_cmd.wr) && !s_if.waitrequest;
      x0  = s_if.readdatavalid && m_ids.size() > 0 && m_ids[0] == 1'b0;
      x1  = s_if.readdatavalid && m_ids.size() > 0 && m_ids[0] == 1'b1;
      check("s_read", s_if.read, m_cmd.rd);
      check("s_write", s_if.write, m_cmd.wr);
      check("s_address", s_if.address, m_cmd.addr);
      check("s_writedata", s_if.writedata, m_cmd.data);
      check("s_byteenable", s_if.byteenable, m_cmd.be);
      check("m0_waitrequest", m0_if.waitrequest, !(acc && m_grant == 1'b0));
      check("m1_waitrequest", m1_if.waitrequest, !(acc && m_grant == 1'b1));
      check("m0_readdatavalid", m0_if.readdatavalid, x0);
      check("m1_readdatavalid", m1_if.readdatavalid, x1);
      if (x0) check("m0_readdata", m0_if.readdata, s_if.readdata);
      if (x1) check("m1_readdata", m1_if.readdata, s_if.readdata);
      check("err_unexpected_rdv", err, m_err);

      if (m0_if.readdatavalid) rx0.push_back(m0_if.readdata);
      if (m1_if.readdatavalid) rx1.push_back(m1_if.readdata);
      if (!m0_if.waitrequest) begin acc_order.push_back(1'b0); cnt_wr0_low++; end
      if (!m1_if.waitrequest) begin acc_order.push_back(1'b1); cnt_wr1_low++; end
      if (s_if.write && s_if.waitrequest) cnt_stall_wr++;

      occ = m_ids.size();
      if (rst) begin
        m_cmd  = '{rd: 1'b0, wr: 1'b0, addr: '0, data: '0, be: '0};
        m_last = 1'b1;
        m_err  = 1'b0;
        m_ids.delete();
      end else begin
        if (s_if.readdatavalid) begin
          if (m_ids.size() > 0) void'(m_ids.pop_front());
          else m_err = 1'b1;
        end
        if (m_cmd.rd || m_cmd.wr) begin
          if (acc) begin
            if (m_cmd.rd) m_ids.push_back(m_grant);
            m_cmd.rd = 1'b0;
            m_cmd.wr = 1'b0;
          end
        end else begin
          t0 = m0_if.read && occ < MAXP;
          t1 = m1_if.read && occ < MAXP;
          e0 = m0_if.write || t0;
          e1 = m1_if.write || t1;
          if (e0 || e1) begin
            g       = (e0 && e1) ? !m_last : e1;
            m_grant = g;
            m_last  = g;
            if (g == 1'b0) begin
              m_cmd.rd = t0; m_cmd.wr = !t0; m_cmd.addr = m0_if.address;
              m_cmd.data = m0_if.writedata; m_cmd.be = m0_if.byteenable;
            end else begin
              m_cmd.rd = t1; m_cmd.wr = !t1; m_cmd.addr = m1_if.address;
              m_cmd.data = m1_if.writedata; m_cmd.be = m1_if.byteenable;
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
    m0_if.writedata = '0; m0_if.byteenable = '0;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
    m1_if.writedata = '0; m1_if.byteenable = '0;
    s_if.waitrequest = 1'b0; s_if.readdatavalid = 1'b0; s_if.readdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_s_read", s_if.read, 1'b0);
    check("rst_s_write", s_if.write, 1'b0);
    check("rst_s_address", s_if.address, 22'h0);
    check("rst_m0_waitrequest", m0_if.waitrequest, 1'b1);
    check("rst_err", err, 1'b0);

    // Single write with a 3-cycle controller stall
    s_if.waitrequest = 1'b1;
    q0.push_back(mk_wr(22'h00010, 16'hBEEF, 2'b11));
    tick();
    check("wr_s_write", s_if.write, 1'b1);
    check("wr_s_address", s_if.address, 22'h00010);
    check("wr_s_writedata", s_if.writedata, 16'hBEEF);
    check("wr_s_byteenable", s_if.byteenable, 2'b11);
    tick();
    tick();
    tick();
    s_if.waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("wr_stall_cycles", cnt_stall_wr, 3);
    check("wr_m0_accepts", cnt_wr0_low, 1);
    check("wr_m1_accepts", cnt_wr1_low, 0);
    check("wr_q0_drained", q0.size(), 0);

    // Tie: both masters read twice, controller returns after 2..5 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_order.delete(); rx0.delete(); rx1.delete();
    q0.push_back(mk_rd(22'h00100)); q0.push_back(mk_rd(22'h00101));
    q1.push_back(mk_rd(22'h20000)); q1.push_back(mk_rd(22'h20001));
    for (int t = 1; t <= 14; t++) begin
      tick();
      s_if.readdatavalid = (t == 3 || t == 6 || t == 9 || t == 12);
      s_if.readdata = (t == 3) ? 16'h1111 : (t == 6) ? 16'h2222 :
                      (t == 9) ? 16'h3333 : (t == 12) ? 16'h4444 : 16'h0000;
    end
    check("tie_accepts", acc_order.size(), 4);
    check("tie_order", {acc_order.size() > 0 ? acc_order[0] : 1'bx,
                        acc_order.size() > 1 ? acc_order[1] : 1'bx,
                        acc_order.size() > 2 ? acc_order[2] : 1'bx,
                        acc_order.size() > 3 ? acc_order[3] : 1'bx}, 4'b0101);
    check("tie_rx0_n", rx0.size(), 2);
    check("tie_rx0_0", qget(rx0, 0), 16'h1111);
    check("tie_rx0_1", qget(rx0, 1), 16'h3333);
    check("tie_rx1_n", rx1.size(), 2);
    check("tie_rx1_0", qget(rx1, 0), 16'h2222);
    check("tie_rx1_1", qget(rx1, 1), 16'h4444);

    // Tracking full: fifth m1 read waits, m0 write still goes through
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx1.delete();
    for (int i = 0; i < 5; i++) q1.push_back(mk_rd(22'(i)));
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (t == 8) q0.push_back(mk_wr(22'h00055, 16'h1234, 2'b01));
      if (t == 14) begin
        check("full_m1_stalled", q1.size(), 1);
        check("full_m0_write_done", q0.size(), 0);
        check("full_s_read_idle", s_if.read, 1'b0);
      end
      if (t == 19) check("full_m1_unblocked", q1.size(), 0);
      s_if.readdatavalid = (t == 15) || (t >= 20 && t <= 23);
      s_if.readdata = (t == 15) ? 16'hAAAA : 16'(16'hB000 + t);
    end
    check("full_rx1_n", rx1.size(), 5);
    check("full_rx1_0", qget(rx1, 0), 16'hAAAA);
    check("full_err", err, 1'b0);

    // Read data with nothing outstanding
    s_if.readdatavalid = 1'b1;
    s_if.readdata = 16'h5A5A;
    tick();
    s_if.readdatavalid = 1'b0;
    tick();
    check("unexp_err_set", err, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("unexp_err_sticky", err, 1'b1);

    // Reset while a stalled write is in flight and two reads are pending
    q0.push_back(mk_rd(22'h00200));
    q1.push_back(mk_rd(22'h00300));
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 4) begin
        q0.push_back(mk_wr(22'h3FFFFF, 16'hFFFF, 2'b10));
        s_if.waitrequest = 1'b1;
      end
      if (t == 5) check("mid_busy_write", s_if.write, 1'b1);
      if (t == 6) begin
        rst = 1'b1;
        q0.delete();
      end
    end
    tick();
    rst = 1'b0;
    s_if.waitrequest = 1'b0;
    check("rstmid_s_read", s_if.read, 1'b0);
    check("rstmid_s_write", s_if.write, 1'b0);
    check("rstmid_s_address", s_if.address, 22'h0);
    check("rstmid_s_byteenable", s_if.byteenable, 2'b00);
    check("rstmid_err", err, 1'b0);
    s_if.readdatavalid = 1'b1;
    tick();
    s_if.readdatavalid = 1'b0;
    tick();
    check("late_rdv_err", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("final_err_cleared", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
